// File: rtl/alu_result_stage_if.sv
// Handshake bundle between ALU producer, result stage and bus consumer.
// Producer/consumer side is the master; the result stage is the slave.
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_lo;
    logic [WIDTH-1:0] in_hi;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z_lo;
    logic [WIDTH-1:0] z_hi;
    logic [TAG_W-1:0] z_tag;
    logic             z_zero;
    logic             z_neg;

    modport master (
        output in_valid, in_lo, in_hi, in_tag, out_ready,
        input  in_ready, out_valid, z_lo, z_hi, z_tag, z_zero, z_neg
    );

    modport slave (
        input  in_valid, in_lo, in_hi, in_tag, out_ready,
        output in_ready, out_valid, z_lo, z_hi, z_tag, z_zero, z_neg
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid buffer holding {hi,lo,tag}
// plus zero/neg flags of the low word, captured at push time.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic              clock,
    input  logic              clear,
    alu_result_stage_if.slave bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
    } ent_t;

    logic [1:0] state_q, state_d;
    ent_t       head_q, head_d;
    ent_t       tail_q, tail_d;
    ent_t       new_ent;
    logic       in_ready;
    logic       out_valid;
    logic       push;
    logic       pop;

    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    assign new_ent.hi   = bus.in_hi;
    assign new_ent.lo   = bus.in_lo;
    assign new_ent.tag  = bus.in_tag;
    assign new_ent.zero = (bus.in_lo == '0);
    assign new_ent.neg  = bus.in_lo[WIDTH-1];

    // Occupancy FSM; vacated entries are zeroed so no stale data shows on z_*
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = new_ent;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = new_ent;
                end else if (push) begin
                    tail_d  = new_ent;
                    state_d = S_TWO;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = S_ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = S_EMPTY;
            end
        endcase
    end

    // State and entry registers, cleared asynchronously
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.z_lo      = head_q.lo;
    assign bus.z_hi      = head_q.hi;
    assign bus.z_tag     = head_q.tag;
    assign bus.z_zero    = head_q.zero;
    assign bus.z_neg     = head_q.neg;
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed steps then random traffic,
// checked against a queue model of a 2-deep FIFO.
module tb_alu_result_stage;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  tag;
    } item_t;

    logic  clk;
    logic  clear;
    int    checks;
    int    errors;
    item_t q[$];

    alu_result_stage_if #(.WIDTH(32), .TAG_W(5)) bus ();

    alu_result_stage #(.WIDTH(32), .TAG_W(5)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        item_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(q.size() < 2));
        chk({tag, ".z_lo"}, 64'(bus.z_lo), 64'(h.lo));
        chk({tag, ".z_hi"}, 64'(bus.z_hi), 64'(h.hi));
        chk({tag, ".z_tag"}, 64'(bus.z_tag), 64'(h.tag));
        chk({tag, ".z_zero"}, 64'(bus.z_zero),
            64'((q.size() != 0) && (h.lo == 32'h0)));
        chk({tag, ".z_neg"}, 64'(bus.z_neg),
            64'((q.size() != 0) && h.lo[31]));
    endtask

    // Called at a negedge; drives inputs, clocks once, updates model, checks.
    task automatic cycle(input string tag, input logic v, input logic [31:0] lo,
                         input logic [31:0] hi, input logic [4:0] tg,
                         input logic ordy);
        bit    do_push;
        bit    do_pop;
        item_t it;
        bus.in_valid  = v;
        bus.in_lo     = lo;
        bus.in_hi     = hi;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        do_push = v && (q.size() < 2);
        do_pop  = (q.size() != 0) && ordy;
        it.hi  = hi;
        it.lo  = lo;
        it.tag = tg;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(it);
        check_model(tag);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_lo     = 32'hCAFEF00D;
        bus.in_hi     = 32'h12345678;
        bus.in_tag    = 5'd7;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.z_lo", 64'(bus.z_lo), 64'd0);
        check_model("rst");
        @(negedge clk);
        clear = 1'b1;

        cycle("first_push", 1'b1, 32'h0000_00AA, 32'h0, 5'd1, 1'b0);
        chk("first_push.accepted", 64'(bus.z_lo), 64'h0000_00AA);
        cycle("first_pop", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);

        cycle("single", 1'b1, 32'h52D2D2D2, 32'h0, 5'd3, 1'b1);
        chk("single.z_lo", 64'(bus.z_lo), 64'h52D2D2D2);
        chk("single.z_neg", 64'(bus.z_neg), 64'd0);
        chk("single.z_zero", 64'(bus.z_zero), 64'd0);
        cycle("single_drain", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
        chk("single_drain.out_valid", 64'(bus.out_valid), 64'd0);

        cycle("fill1", 1'b1, 32'h00000001, 32'h0, 5'd4, 1'b0);
        cycle("fill2", 1'b1, 32'h1BD5B7DD, 32'h0, 5'd5, 1'b0);
        chk("fill2.in_ready", 64'(bus.in_ready), 64'd0);
        cycle("fill3", 1'b1, 32'h00123456, 32'h0, 5'd6, 1'b0);
        chk("fill3.in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill3.head_held", 64'(bus.z_lo), 64'h00000001);
        chk("drain0.z_lo", 64'(bus.z_lo), 64'h00000001);
        cycle("drain1", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
        chk("drain1.z_lo", 64'(bus.z_lo), 64'h1BD5B7DD);
        cycle("drain2", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
        chk("drain2.out_valid", 64'(bus.out_valid), 64'd0);

        cycle("simul_a", 1'b1, 32'hFFFFFFFF, 32'hDEAD0000, 5'd9, 1'b0);
        chk("simul_a.z_neg", 64'(bus.z_neg), 64'd1);
        cycle("simul_b", 1'b1, 32'h00000000, 32'h0000BEEF, 5'd10, 1'b1);
        chk("simul_b.z_lo", 64'(bus.z_lo), 64'd0);
        chk("simul_b.z_zero", 64'(bus.z_zero), 64'd1);
        chk("simul_b.z_neg", 64'(bus.z_neg), 64'd0);
        chk("simul_b.in_ready", 64'(bus.in_ready), 64'd1);
        cycle("simul_c", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);

        cycle("ar_fill1", 1'b1, 32'h80000000, 32'h11111111, 5'd11, 1'b0);
        cycle("ar_fill2", 1'b1, 32'h7FFFFFFF, 32'h22222222, 5'd12, 1'b0);
        bus.in_valid = 1'b1;
        #2 clear = 1'b0;
        #1;
        q.delete();
        chk("async.out_valid", 64'(bus.out_valid), 64'd0);
        chk("async.z_lo", 64'(bus.z_lo), 64'd0);
        chk("async.z_hi", 64'(bus.z_hi), 64'd0);
        check_model("async");
        @(negedge clk);
        clear = 1'b1;
        cycle("post_rst", 1'b1, 32'h00000042, 32'h0, 5'd2, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] lo;
            lo = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            cycle("rand", ($urandom_range(0, 3) != 0), lo, $urandom,
                  5'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++)
            cycle("final_drain", 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
